// File: rtl/shift_issue_stage.sv
// shift_issue_stage: decodes R-type shift instructions into barrel-shifter operands behind a 2-entry skid buffer.
// Optional issued-shift counter enabled by defining SHIFT_ISSUE_PERF_EN.
module shift_issue_stage #(
    parameter int N_bits = 32,
    localparam int SA_bits = $clog2(N_bits)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [5:0]         funct,
    input  logic [SA_bits-1:0] shamt,
    input  logic [N_bits-1:0]  rs,
    input  logic [N_bits-1:0]  rt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [N_bits-1:0]  d,
    output logic [SA_bits-1:0] shift_amount,
    output logic               right,
    output logic               arith,
    output logic               illegal,
    output logic [31:0]        perf_count
);
    typedef struct packed {
        logic [N_bits-1:0]  d;
        logic [SA_bits-1:0] amt;
        logic               right;
        logic               arith;
        logic               illegal;
    } op_t;
    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;
    state_t r_state, w_state_nxt;
    op_t    r_main, r_skid, w_dec;
    logic   r_in_ready;
    logic   w_legal, w_accept, w_present;
    logic   w_load_main_in, w_load_main_skid, w_load_skid;
    logic   w_unused_rs;
    assign w_unused_rs = ^rs[N_bits-1:SA_bits];
    // Shift opcodes are 000xyz with yz != 01; funct[2] selects the variable form.
    assign w_legal = (funct[5:3] == 3'b000) && (funct[1:0] != 2'b01);
    always_comb begin
        w_dec         = '0;
        w_dec.d       = rt;
        w_dec.illegal = !w_legal;
        w_dec.amt     = !w_legal ? '0 : funct[2] ? rs[SA_bits-1:0] : shamt;
        w_dec.right   = w_legal & funct[1];
        w_dec.arith   = w_legal & funct[1] & funct[0];
    end
    assign out_valid = (r_state != EMPTY);
    assign in_ready  = r_in_ready;
    assign w_accept  = in_valid & r_in_ready;
    assign w_present = out_valid & out_ready;
    always_comb begin
        w_state_nxt      = r_state;
        w_load_main_in   = 1'b0;
        w_load_main_skid = 1'b0;
        w_load_skid      = 1'b0;
        case (r_state)
            EMPTY: begin
                w_state_nxt    = w_accept ? ONE : EMPTY;
                w_load_main_in = w_accept;
            end
            ONE: begin
                w_state_nxt    = (w_accept && !w_present) ? FULL :
                                 (w_present && !w_accept) ? EMPTY : ONE;
                w_load_main_in = w_accept && w_present;
                w_load_skid    = w_accept && !w_present;
            end
            FULL: begin
                w_state_nxt      = w_present ? ONE : FULL;
                w_load_main_skid = w_present;
            end
            default: w_state_nxt = EMPTY;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= EMPTY;
            r_in_ready <= 1'b1;
            r_main     <= '0;
            r_skid     <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != FULL);
            if (w_load_main_in)
                r_main <= w_dec;
            else if (w_load_main_skid)
                r_main <= r_skid;
            if (w_load_skid)
                r_skid <= w_dec;
        end
    end
    assign d            = r_main.d;
    assign shift_amount = r_main.amt;
    assign right        = r_main.right;
    assign arith        = r_main.arith;
    assign illegal      = r_main.illegal;
`ifdef SHIFT_ISSUE_PERF_EN
    logic [31:0] r_perf_count;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_perf_count <= '0;
        else if (w_present && !r_main.illegal)
            r_perf_count <= r_perf_count + 32'd1;
    end
    assign perf_count = r_perf_count;
`else
    assign perf_count = '0;
`endif
endmodule

// File: tb/tb_shift_issue_stage.sv
// tb_shift_issue_stage: randomized scoreboard bench for shift_issue_stage against a decode-table model.
module tb_shift_issue_stage;
    logic        clk = 0, rst_n = 0, in_valid = 0, out_ready = 0;
    logic        in_ready, out_valid, right, arith, illegal;
    logic [5:0]  funct = 0;
    logic [4:0]  shamt = 0, shift_amount;
    logic [31:0] rs = 0, rt = 0, d, perf_count;
    int          total = 0, bad = 0, or_mode = 1;
    logic [39:0] q[$];
    logic [31:0] perf_model = 0;
    logic        prev_stall = 0;
    logic [39:0] prev_out = 0;
    logic [5:0]  legal_f [6] = '{6'd0, 6'd2, 6'd3, 6'd4, 6'd6, 6'd7};
    wire  [39:0] cur = {d, shift_amount, right, arith, illegal};

    shift_issue_stage dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .funct(funct), .shamt(shamt), .rs(rs), .rt(rt),
        .out_valid(out_valid), .out_ready(out_ready), .d(d),
        .shift_amount(shift_amount), .right(right), .arith(arith),
        .illegal(illegal), .perf_count(perf_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    function automatic logic [39:0] model(input logic [5:0] f, input logic [4:0] sh,
                                          input logic [31:0] s, input logic [31:0] t);
        logic [4:0] amt = 0;
        logic r = 0, a = 0, ill = 0;
        case (f)
            6'd0: amt = sh;
            6'd2: begin amt = sh; r = 1; end
            6'd3: begin amt = sh; r = 1; a = 1; end
            6'd4: amt = 5'(s % 32);
            6'd6: begin amt = 5'(s % 32); r = 1; end
            6'd7: begin amt = 5'(s % 32); r = 1; a = 1; end
            default: ill = 1;
        endcase
        return {t, amt, r, a, ill};
    endfunction

    always @(posedge clk) begin
        #1;
        out_ready = (or_mode == 2) ? 1'($urandom_range(0, 1)) : (or_mode == 1);
    end

    always @(negedge clk) begin
        if (!rst_n) prev_stall = 0;
        else begin
            check("out_valid", out_valid, q.size() > 0);
            check("in_ready", in_ready, q.size() < 2);
`ifdef SHIFT_ISSUE_PERF_EN
            check("perf_count", perf_count, perf_model);
`else
            check("perf_count", perf_count, 0);
`endif
            if (prev_stall) check("hold", cur, prev_out);
            if (out_valid && out_ready && q.size() > 0) begin
                logic [39:0] e;
                e = q.pop_front();
                check("out_data", cur, e);
                if (!e[0]) perf_model++;
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = cur;
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accepting edge.
    task automatic send(input logic [5:0] f, input logic [4:0] sh, input logic [31:0] s, input logic [31:0] t);
        int n = 0;
        in_valid = 1; funct = f; shamt = sh; rs = s; rt = t;
        while (1) begin
            @(negedge clk); #1;
            if (in_ready) begin
                q.push_back(model(f, sh, s, t));
                @(posedge clk); #1;
                in_valid = 0; funct = 6'($urandom); shamt = 5'($urandom); rs = $urandom; rt = $urandom;
                return;
            end
            if (++n > 50) begin
                check("accept_timeout", n, 0);
                in_valid = 0;
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        #12;
        check("reset_out_valid", out_valid, 0);
        check("reset_in_ready", in_ready, 1);
        check("reset_outputs", cur, 0);
        check("reset_perf", perf_count, 0);
        rst_n = 1;
        @(posedge clk); #1;
        idle(1);
        send(6'b000011, 5'd4, $urandom, 32'h8000_00F0);
        check("sra_out", {out_valid, cur}, {1'b1, 32'h8000_00F0, 5'd4, 1'b1, 1'b1, 1'b0});
        send(6'b000110, 5'($urandom), 32'h0000_0123, 32'hFFFF_0000);
        check("srlv_out", {shift_amount, right, arith, illegal}, {5'd3, 1'b1, 1'b0, 1'b0});
        or_mode = 0;
        idle(2);
        send(6'b000000, 5'd1, $urandom, $urandom);
        send(6'b000000, 5'd2, $urandom, $urandom);
        check("in_ready_full", in_ready, 0);
        or_mode = 1;
        send(6'b000000, 5'd3, $urandom, $urandom);
        idle(4);
        check("b2b_drained", q.size(), 0);
        send(6'b100000, 5'($urandom), $urandom, 32'h1234_5678);
        check("illegal_out", {cur}, {32'h1234_5678, 5'd0, 1'b0, 1'b0, 1'b1});
        idle(2);
        or_mode = 0;
        idle(2);
        send(6'b000010, 5'($urandom), $urandom, $urandom);
        send(6'b000111, 5'($urandom), $urandom, $urandom);
        #2 rst_n = 0;
        #1;
        check("arst_out_valid", out_valid, 0);
        check("arst_in_ready", in_ready, 1);
        check("arst_outputs", cur, 0);
        check("arst_perf", perf_count, 0);
        q.delete();
        perf_model = 0;
        #3 rst_n = 1;
        or_mode = 1;
        @(posedge clk); #1;
        idle(3);
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
            send(($urandom_range(0, 3) != 0) ? legal_f[$urandom_range(0, 5)] : 6'($urandom),
                 5'($urandom), $urandom, $urandom);
        end
        or_mode = 1;
        for (int n = 0; n < 50 && q.size() > 0; n++) idle(1);
        check("drain", q.size(), 0);
        idle(2);
`ifdef SHIFT_ISSUE_PERF_EN
        @(negedge clk); #2;
        force dut.r_perf_count = 32'hFFFF_FFFF;
        perf_model = 32'hFFFF_FFFF;
        #1 release dut.r_perf_count;
        @(posedge clk); #1;
        send(6'b000000, 5'd1, $urandom, $urandom);
        idle(3);
        check("perf_wrap", perf_count, 0);
`else
        check("perf_off", perf_count, 0);
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
